inst_rom_resp: RTL and testbench
================================

// Module: inst_rom_resp
// PURPOSE
//  Responder end of the instruction-fetch interface: serves word reads from a
//  core's PC stage (rom_ce/rom_addr out, rom_data in). Backed by an on-chip word
//  array, with programmable access wait states and a ready strobe.
//  A side load port lets the bench or boot logic write program words.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of array depth in 32-bit words (1024 words)
//  WAIT_CYCLES   1  extra access cycles per fetch, legal 0..7
//  NOP_WORD     32'h0000_0000  data returned on error or when ce is low
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            reset, asynchronous, active-low (0 = reset)
//  rom_ce_i     in   1            fetch enable from PC stage
//  rom_addr_i   in   32           byte address of fetch
//  rom_data_o   out  32           fetched instruction word (registered)
//  rom_ready_o  out  1            1-cycle strobe: rom_data_o valid this cycle
//  rom_err_o    out  1            1-cycle strobe with ready: misaligned/out-of-range
//  busy_o       out  1            request in flight (state != IDLE)
//  load_we_i    in   1            program-load write enable
//  load_addr_i  in   DEPTH_LOG2   program-load word index
//  load_data_i  in   32           program-load data
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait counter=0, rom_data_o=NOP_WORD,
//    rom_ready_o=0, rom_err_o=0, busy_o=0. Array contents are NOT reset.
//  - FSM IDLE/WAIT/RESP. Request is accepted on an edge with rom_ce_i=1 while in
//    IDLE or RESP; addr is captured; next state WAIT (cnt=WAIT_CYCLES-1) if
//    WAIT_CYCLES>0, else RESP.
//  - WAIT: cnt decrements each edge; at cnt==0 -> RESP. rom_ce_i=0 in WAIT aborts:
//    -> IDLE, no ready, rom_data_o unchanged.
//  - Edge entering RESP registers rom_data_o=mem[addr[DEPTH_LOG2+1:2]] and
//    sets rom_ready_o=1 for exactly the RESP cycle.
//  - Latency: ready asserts WAIT_CYCLES+1 edges after the accept edge.
//    Back-to-back throughput: one word per WAIT_CYCLES+1 cycles.
//  - Error: addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0 -> rom_data_o=NOP_WORD with
//    rom_ready_o=1 and rom_err_o=1 in the same cycle; latency is unchanged.
//  - IDLE with rom_ce_i=0: rom_data_o is loaded with NOP_WORD on the next edge.
//  - Load write: synchronous, has priority, and is never stalled by fetches. A
//    write and a data-register load to the same index on one edge return OLD data
//    (read-before-write).
//  - Address wrap: none; indices beyond depth are errors, not aliased.
// CONFIGURATION
//  INST_ROM_PREFETCH_EN defined: one-word prefetch buffer (tag+data+valid).
//   - After each non-error RESP, read word idx+1 into the buffer on the next idle
//     edge; at the last index, no prefetch is done.
//   - A later request whose index hits the valid tag goes straight to RESP
//     (1-cycle latency) regardless of WAIT_CYCLES.
//   - A load write to the buffered index, or reset, clears valid.
//  Undefined: no buffer; every fetch takes WAIT_CYCLES+1 cycles.
// STRUCTURE
//  - Shared package inst_rom_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1,
//    RESP=2'd2), NOP_WORD default, WordBus/InstAddrBus widths.
//  - Sub-module inst_rom_mem: DEPTH word array, one sync write port, one
//    registered read port. It is shared with the prefetch read via a 2:1 index
//    mux; a demand fetch has priority over a prefetch.
// TESTING
//  1 Reset: hold rst=0 mid-WAIT, release -> state IDLE, ready=0,
//    rom_data_o=0x00000000.
//  2 Basic fetch, WAIT_CYCLES=1: load mem[4]=0x24010005; ce=1, addr=0x10 ->
//    ready exactly 2 edges later, data=0x24010005, err=0.
//  3 Streaming: ce held, addr 0x0,0x4,0x8 each accept -> 3 ready pulses spaced 2
//    cycles apart, data in order.
//  4 Errors: addr=0x12 -> ready+err, data=0; addr=0x00001000 (DEPTH_LOG2=10) ->
//    ready+err, data=0.
//  5 Abort/collision: drop ce in WAIT -> no ready. Load mem[4]=0xDEADBEEF on the
//    RESP-entry edge of a fetch to 0x10 -> old word returned; refetch ->
//    0xDEADBEEF.
//  6 PREFETCH_EN, WAIT_CYCLES=3: fetch 0x20, then 0x24 -> second fetch ready after
//    1 cycle. Rewrite mem[9] before the second fetch -> full 4-cycle latency, new
//    data returned.

Source files
------------

// File: rtl/inst_rom_pkg.sv
// ---------------------------------------------------------------------------
// inst_rom_pkg
// Shared definitions for the instruction ROM responder slice:
//   - bus widths of the fetch interface
//   - default NOP word returned on errors / idle
//   - FSM state encoding of the responder
//   - select code for the registered read-data output mux
// ---------------------------------------------------------------------------
package inst_rom_pkg;

    // Widths of the instruction-fetch interface.
    localparam int WordBus     = 32;
    localparam int InstAddrBus = 32;

    // Width of the wait-state counter (wait states are limited to 0..7).
    localparam int WaitCntW = 3;

    // Word handed back on errors and while the fetch enable is low.
    localparam logic [WordBus-1:0] NopWordDefault = 32'h0000_0000;

    // Responder FSM states. The encoding is visible to anyone probing the
    // state register, so it is pinned explicitly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } romState_e;

    // Source feeding rom_data_o. The data output is a registered value held
    // in one of three places: the NOP constant, the array read register, or
    // the prefetch buffer.
    typedef enum logic [1:0] {
        SEL_NOP = 2'd0,
        SEL_MEM = 2'd1,
        SEL_BUF = 2'd2
    } dataSel_e;

endpackage

// File: rtl/inst_rom_mem.sv
// ---------------------------------------------------------------------------
// inst_rom_mem
// On-chip word array backing the instruction ROM responder.
// One synchronous write port and one registered read port. A write and a read
// of the same index on the same edge return the OLD word (read-before-write).
// The array and the read register are deliberately not reset.
//
// Ports
//   clk       in   1            rising-edge clock
//   we_i      in   1            write enable
//   waddr_i   in   DEPTH_LOG2   write word index
//   wdata_i   in   32           write data
//   re_i      in   1            read enable (read register holds when low)
//   raddr_i   in   DEPTH_LOG2   read word index
//   rdata_o   out  32           registered read data
// ---------------------------------------------------------------------------
module inst_rom_mem
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WordBus-1:0]    wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WordBus-1:0]    rdata_o
);

    localparam int Depth = 1 << DEPTH_LOG2;

    logic [WordBus-1:0] mem_q [Depth];
    logic [WordBus-1:0] rdata_q;

    // Both ports live in one clocked block; the non-blocking update of the
    // array means a same-edge read still sees the previous contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_resp.sv
// ---------------------------------------------------------------------------
// inst_rom_resp
// Responder end of the instruction-fetch interface. Serves 32-bit word reads
// requested by a core's PC stage from an on-chip word array, inserting a
// programmable number of wait states and pulsing a ready strobe when the
// registered data is valid. A side load port writes program words.
//
// Optional feature, macro INST_ROM_PREFETCH_EN:
//   one-word prefetch buffer (tag + data + valid). After a good response the
//   next word is read on the following idle edge; a request hitting the
//   buffered index is answered one edge after acceptance.
//
// Parameters
//   DEPTH_LOG2   log2 of array depth in words
//   WAIT_CYCLES  extra access cycles per fetch (0..7)
//   NOP_WORD     data returned on error or while idle
//
// Ports
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous reset, active low
//   rom_ce_i     in   1            fetch enable
//   rom_addr_i   in   32           fetch byte address
//   rom_data_o   out  32           fetched word (registered)
//   rom_ready_o  out  1            one-cycle strobe, rom_data_o valid
//   rom_err_o    out  1            one-cycle strobe with ready on bad address
//   busy_o       out  1            request in flight
//   load_we_i    in   1            program-load write enable
//   load_addr_i  in   DEPTH_LOG2   program-load word index
//   load_data_i  in   32           program-load data
// ---------------------------------------------------------------------------
module inst_rom_resp
    import inst_rom_pkg::*;
#(
    parameter int                 DEPTH_LOG2  = 10,
    parameter int                 WAIT_CYCLES = 1,
    parameter logic [WordBus-1:0] NOP_WORD    = NopWordDefault
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [WordBus-1:0]     rom_data_o,
    output logic                   rom_ready_o,
    output logic                   rom_err_o,
    output logic                   busy_o,
    input  logic                   load_we_i,
    input  logic [DEPTH_LOG2-1:0]  load_addr_i,
    input  logic [WordBus-1:0]     load_data_i
);

    localparam logic [WaitCntW-1:0] CntInit =
        (WAIT_CYCLES > 0) ? WaitCntW'(WAIT_CYCLES - 1) : '0;

    // FSM and registered outputs
    romState_e             state_q;
    logic [WaitCntW-1:0]   cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  err_q;
    dataSel_e              sel_q;
    logic                  ready_q;
    logic                  errOut_q;

    // Request decode and array read control
    logic [DEPTH_LOG2-1:0] reqIdx;
    logic                  reqErr;
    logic                  acceptReq;
    logic                  waitDone;
    logic                  hit;
    logic                  fastResp;
    logic                  respErr;
    dataSel_e              sel_d;
    logic                  demandRe;
    logic [DEPTH_LOG2-1:0] demandIdx;
    logic                  memRe;
    logic [DEPTH_LOG2-1:0] memRaddr;
    logic [WordBus-1:0]    memRdata;

`ifdef INST_ROM_PREFETCH_EN
    logic                  bufValid_q;
    logic                  pfPending_q;
    logic                  pfReq_q;
    logic [DEPTH_LOG2-1:0] bufTag_q;
    logic [DEPTH_LOG2-1:0] pfIdx_q;
    logic [WordBus-1:0]    bufData_q;
    logic                  writeHitsTag;
    logic                  pfRe;
    logic                  respEnter;
    logic [DEPTH_LOG2-1:0] respIdx;
`endif

    // Decode the incoming request, decide whether it can be answered on the
    // accept edge, and steer the single array read port. Demand reads only
    // happen on the edge entering RESP; the prefetch read only happens on an
    // idle edge with the enable low, so the two never collide.
    always_comb begin
        reqIdx    = rom_addr_i[DEPTH_LOG2+1:2];
        reqErr    = (|rom_addr_i[1:0]) || (|rom_addr_i[InstAddrBus-1:DEPTH_LOG2+2]);
        acceptReq = rom_ce_i && ((state_q == IDLE) || (state_q == RESP));
        waitDone  = (state_q == WAIT) && rom_ce_i && (cnt_q == '0);
        hit       = 1'b0;
`ifdef INST_ROM_PREFETCH_EN
        writeHitsTag = load_we_i && (load_addr_i == bufTag_q);
        // A prefetch still in its capture edge counts as a hit: the buffer
        // data register loads on that same edge.
        hit = !reqErr && (bufValid_q || pfPending_q) && (bufTag_q == reqIdx)
              && !writeHitsTag;
`endif
        fastResp  = acceptReq && ((WAIT_CYCLES == 0) || hit);
        respErr   = fastResp ? reqErr : err_q;

        sel_d = SEL_MEM;
        if (respErr) begin
            sel_d = SEL_NOP;
        end else if (fastResp && hit) begin
            sel_d = SEL_BUF;
        end

        demandRe  = (fastResp && !reqErr && !hit) || (waitDone && !err_q);
        demandIdx = waitDone ? idx_q : reqIdx;
        memRe     = demandRe;
        memRaddr  = demandIdx;
`ifdef INST_ROM_PREFETCH_EN
        pfRe      = (state_q == IDLE) && !rom_ce_i && pfReq_q;
        respEnter = fastResp || waitDone;
        respIdx   = fastResp ? reqIdx : idx_q;
        memRe     = demandRe || pfRe;
        if (!demandRe) begin
            memRaddr = pfIdx_q;
        end
`endif
    end

    // Responder FSM with registered ready/err strobes and the data source
    // select. Ready and err default low so they pulse for exactly the cycle
    // spent in RESP. The select only changes on RESP entry or on an idle edge
    // with the enable low; an aborted wait leaves the data output alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            sel_q    <= SEL_NOP;
            ready_q  <= 1'b0;
            errOut_q <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            errOut_q <= 1'b0;
            unique case (state_q)
                IDLE, RESP: begin
                    if (acceptReq) begin
                        idx_q <= reqIdx;
                        err_q <= reqErr;
                        if (fastResp) begin
                            state_q  <= RESP;
                            ready_q  <= 1'b1;
                            errOut_q <= reqErr;
                            sel_q    <= sel_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CntInit;
                        end
                    end else begin
                        state_q <= IDLE;
                        if (state_q == IDLE) begin
                            sel_q <= SEL_NOP;
                        end
                    end
                end
                WAIT: begin
                    if (!rom_ce_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        errOut_q <= err_q;
                        sel_q    <= sel_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef INST_ROM_PREFETCH_EN
    // Prefetch bookkeeping. A good response arms a request for the next
    // index (none past the last word). The read is issued on the next idle
    // edge, and the array read register is copied into the buffer one edge
    // later. Any load write to the buffered index drops the buffer, including
    // a write landing during the capture edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bufValid_q  <= 1'b0;
            pfPending_q <= 1'b0;
            pfReq_q     <= 1'b0;
            bufTag_q    <= '0;
            pfIdx_q     <= '0;
            bufData_q   <= '0;
        end else begin
            if (pfPending_q) begin
                bufData_q   <= memRdata;
                bufValid_q  <= !writeHitsTag;
                pfPending_q <= 1'b0;
            end else if (writeHitsTag) begin
                bufValid_q <= 1'b0;
            end

            if (respEnter) begin
                pfReq_q <= !respErr && (respIdx != '1);
                pfIdx_q <= respIdx + 1'b1;
            end else if (acceptReq || pfRe) begin
                pfReq_q <= 1'b0;
            end

            if (pfRe) begin
                bufTag_q    <= pfIdx_q;
                bufValid_q  <= 1'b0;
                pfPending_q <= !(load_we_i && (load_addr_i == pfIdx_q));
            end
        end
    end
`endif

    inst_rom_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (load_we_i),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .re_i    (memRe),
        .raddr_i (memRaddr),
        .rdata_o (memRdata)
    );

    // Output data mux over registered sources only.
    always_comb begin
        rom_data_o = NOP_WORD;
        case (sel_q)
            SEL_MEM: rom_data_o = memRdata;
`ifdef INST_ROM_PREFETCH_EN
            SEL_BUF: rom_data_o = bufData_q;
`endif
            default: rom_data_o = NOP_WORD;
        endcase
    end

    assign rom_ready_o = ready_q;
    assign rom_err_o   = errOut_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_inst_rom_resp.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_resp
// Directed testbench for inst_rom_resp. With INST_ROM_PREFETCH_EN defined the
// responder runs with three wait states and the prefetch hit is expected to
// answer one edge after acceptance; otherwise one wait state and no buffer.
// ---------------------------------------------------------------------------
module tb_inst_rom_resp;

`ifdef INST_ROM_PREFETCH_EN
   localparam int TbWait = 3;
   localparam bit TbPf   = 1'b1;
`else
   localparam int TbWait = 1;
   localparam bit TbPf   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic [31:0] addr = 32'h0;
   logic        we = 1'b0;
   logic [9:0]  ldAddr = 10'h0;
   logic [31:0] ldData = 32'h0;
   logic [31:0] romData;
   logic        romReady;
   logic        romErr;
   logic        busy;

   int checks = 0;
   int failures = 0;

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   inst_rom_resp #(
      .DEPTH_LOG2  (10),
      .WAIT_CYCLES (TbWait),
      .NOP_WORD    (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_ce_i    (ce),
      .rom_addr_i  (addr),
      .rom_data_o  (romData),
      .rom_ready_o (romReady),
      .rom_err_o   (romErr),
      .busy_o      (busy),
      .load_we_i   (we),
      .load_addr_i (ldAddr),
      .load_data_i (ldData)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive the fetch-side inputs
   task automatic applyStimulus(input logic enable, input logic [31:0] byteAddr);
      ce = enable;
      addr = byteAddr;
   endtask

   // One program-load write, called at a negedge, returns at a negedge
   task automatic loadWord(input logic [9:0] idx, input logic [31:0] data);
      we = 1'b1;
      ldAddr = idx;
      ldData = data;
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic idleEdges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Full fetch: raise enable, count edges to ready (bounded), drop enable,
   // check latency/data/err, then confirm ready lasted one cycle
   task automatic fetchWord(input string tag, input logic [31:0] byteAddr,
                            input logic [31:0] expData, input logic expErr,
                            input int expLat);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      applyStimulus(1'b1, byteAddr);
      while (!got && n < 16) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (romReady) got = 1'b1;
      end
      applyStimulus(1'b0, byteAddr);
      checkOutput({tag, "_lat"}, 32'(n), 32'(expLat));
      checkOutput({tag, "_data"}, romData, expData);
      checkOutput({tag, "_err"}, {31'b0, romErr}, {31'b0, expErr});
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_rdyoff"}, {31'b0, romReady}, 32'h0);
   endtask

   // Bound on total run time
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] streamData [3];
      int n;
      bit got;
      int readyCount;

      $display("[TB] start, wait states %0d, prefetch %0d", TbWait, TbPf);

      // Power-on reset values
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_data", romData, 32'h0);
      checkOutput("rst_ready", {31'b0, romReady}, 32'h0);
      checkOutput("rst_err", {31'b0, romErr}, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);

      // Reset asserted in the middle of a wait
      rst = 1'b1;
      applyStimulus(1'b1, 32'h10);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midwait_busy", {31'b0, busy}, 32'h1);
      rst = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
      checkOutput("midrst_ready", {31'b0, romReady}, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0);
      rst = 1'b1;
      idleEdges(1);
      checkOutput("rel_busy", {31'b0, busy}, 32'h0);
      checkOutput("rel_ready", {31'b0, romReady}, 32'h0);
      checkOutput("rel_data", romData, 32'h0);

      // Basic fetch
      loadWord(10'd4, 32'h2401_0005);
      fetchWord("basic", 32'h10, 32'h2401_0005, 1'b0, TbWait + 1);

      // Streaming with enable held: one word per TbWait+1 edges
      streamData[0] = 32'h3C01_1000;
      streamData[1] = 32'h3421_0020;
      streamData[2] = 32'h8C22_0004;
      for (int k = 0; k < 3; k++) loadWord(10'(k), streamData[k]);
      applyStimulus(1'b1, 32'h0);
      for (int k = 0; k < 3; k++) begin
         n = 0;
         got = 1'b0;
         while (!got && n < 16) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (romReady) got = 1'b1;
         end
         checkOutput($sformatf("stream%0d_gap", k), 32'(n), 32'(TbWait + 1));
         checkOutput($sformatf("stream%0d_data", k), romData, streamData[k]);
         if (k < 2) applyStimulus(1'b1, 32'((k + 1) * 4));
         else applyStimulus(1'b0, 32'h0);
      end
      idleEdges(1);
      checkOutput("stream_rdyoff", {31'b0, romReady}, 32'h0);

      // Error cases and the last valid word
      fetchWord("misalign", 32'h12, 32'h0, 1'b1, TbWait + 1);
      fetchWord("range", 32'h0000_1000, 32'h0, 1'b1, TbWait + 1);
      loadWord(10'd1023, 32'h1357_9BDF);
      fetchWord("lastword", 32'h0000_0FFC, 32'h1357_9BDF, 1'b0, TbWait + 1);

      // Abort: enable dropped in WAIT, no ready, data held until idle
      applyStimulus(1'b1, 32'h10);
      idleEdges(1);
      checkOutput("abort_busy", {31'b0, busy}, 32'h1);
      applyStimulus(1'b0, 32'h10);
      idleEdges(1);
      checkOutput("abort_held", romData, 32'h1357_9BDF);
      readyCount = (romReady) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         idleEdges(1);
         if (romReady) readyCount++;
      end
      checkOutput("abort_noready", 32'(readyCount), 32'h0);
      checkOutput("abort_idlenop", romData, 32'h0);

      // Write collision on the RESP-entry edge returns the old word
      applyStimulus(1'b1, 32'h10);
      idleEdges(TbWait);
      we = 1'b1;
      ldAddr = 10'd4;
      ldData = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
      applyStimulus(1'b0, 32'h10);
      checkOutput("coll_ready", {31'b0, romReady}, 32'h1);
      checkOutput("coll_olddata", romData, 32'h2401_0005);
      idleEdges(1);
      fetchWord("refetch", 32'h10, 32'hDEAD_BEEF, 1'b0, TbWait + 1);

      // Sequential fetch: buffered next word (when built in), then a rewrite
      // of that word forcing the full-latency path with the new data
      loadWord(10'd8, 32'h8C22_0020);
      loadWord(10'd9, 32'hAC23_0024);
      fetchWord("seq_first", 32'h20, 32'h8C22_0020, 1'b0, TbWait + 1);
      idleEdges(2);
      fetchWord("seq_next", 32'h24, 32'hAC23_0024, 1'b0, TbPf ? 1 : TbWait + 1);
      fetchWord("seq_again", 32'h20, 32'h8C22_0020, 1'b0, TbWait + 1);
      idleEdges(2);
      loadWord(10'd9, 32'h1111_2222);
      fetchWord("seq_rewrite", 32'h24, 32'h1111_2222, 1'b0, TbWait + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
